implication_consumer: RTL
=========================

# implication_consumer

Downstream stage of the implication FIFO in the BCP accelerator. Pops one implication at a time, checks it against the on-chip variable assignment table and acts on the result:
- unassigned variable: records it and forwards it to the clause-propagation stage over a valid/ready handshake;
- same-value variable: drops it as a duplicate;
- opposite-value variable: raises a sticky conflict.

The block owns the assignment table and exposes a combinational read port so the upstream clause evaluator can look up variable values.

## Interface
- FORMULA_MAX_VARIABLE, 20: highest legal variable index. Variables are 1..MAX; 0 is reserved.
- VARIABLE_ENCODING_LEN, $clog2(FORMULA_MAX_VARIABLE+1): variable index width.
- VARIABLE_ASSIGNMENT_LEN, 1: assignment value width.
- WIDTH, VARIABLE_ENCODING_LEN+VARIABLE_ASSIGNMENT_LEN: implication width. Layout is {var, value}, with value in the LSB.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  permits starting a new pop. Does not stall work already in flight.
- clear_i  in  1  synchronous clear of the table, conflict and counter, e.g. on solver restart.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_o  out  1  FIFO pop request, one-cycle pulse.
- fifo_implication_i  in  WIDTH  FIFO read data. Valid the cycle after fifo_rd_o.
- prop_valid_o  out  1  new assignment available to the downstream stage.
- prop_ready_i  in  1  downstream accepts the assignment.
- prop_var_o  out  VARIABLE_ENCODING_LEN  assigned variable.
- prop_val_o  out  1  assigned value.
- conflict_o  out  1  sticky conflict flag.
- conflict_var_o  out  VARIABLE_ENCODING_LEN  variable that caused the first conflict.
- assign_rd_var_i  in  VARIABLE_ENCODING_LEN  table lookup index.
- assign_rd_o  out  2  combinational lookup result: 2'b00 unassigned, 2'b10 false, 2'b11 true. Index 0 or >MAX returns 2'b00.
- assigned_count_o  out  VARIABLE_ENCODING_LEN  number of assigned variables.

## Operation
FSM states and transitions:
- IDLE: go to READ when en_i && !fifo_empty_i && !conflict_o.
- READ: fifo_rd_o=1 (combinational decode of state). Next state CAPTURE.
- CAPTURE: register fifo_implication_i into cur_var/cur_val. Next state CHECK.
- CHECK: look up table[cur_var].
  - cur_var==0 or cur_var>MAX: discard, go to IDLE.
  - Entry 00: write {1,cur_val}, increment assigned_count, go to EMIT.
  - Entry equals {1,cur_val}: discard, go to IDLE.
  - Otherwise: set conflict_o, latch conflict_var_o=cur_var, go to CONFLICT.
- EMIT: prop_valid_o=1 with stable prop_var_o/prop_val_o. On prop_valid_o && prop_ready_i go to IDLE.
- CONFLICT: hold. No pops. Leave only via clear_i or rst_i.

Global rules:
- rst_i and clear_i have identical effect and override every state:
  - all table entries become 00;
  - conflict_o=0, conflict_var_o=0, assigned_count_o=0;
  - FSM goes to IDLE.
- An implication captured but not yet emitted when rst_i or clear_i arrives is dropped; its FIFO entry is lost.
- en_i low does not abort READ, CAPTURE, CHECK or EMIT.
- assigned_count_o saturates at MAX. It cannot exceed MAX by construction.

## Timing
- Reset values: fifo_rd_o=0, prop_valid_o=0, prop_var_o=0, prop_val_o=0, conflict_o=0, conflict_var_o=0, assigned_count_o=0, all table entries 00.
- Pop latency: IDLE decision at cycle T; fifo_rd_o high in T+1; data captured at the end of T+2; CHECK in T+3; prop_valid_o high from T+4.
- Minimum issue interval is 4 cycles for a drop and 5 cycles for an emit with ready already high.
- The table write performed in CHECK is visible on assign_rd_o from the next cycle.
- prop_var_o, prop_val_o and prop_valid_o are all registered and stay stable while prop_valid_o && !prop_ready_i.
- fifo_rd_o is never asserted while fifo_empty_i is high at the IDLE decision. The block issues at most one pop per 4 cycles.

## Structure
- bcp_pkg holds:
  - the assign_t encoding constants (UNASSIGNED=2'b00, FALSE=2'b10, TRUE=2'b11);
  - the consumer state enum;
  - the implication field-extract helpers (var = bits[WIDTH-1:1], val = bit[0]).
- Sub-module assignment_table: MAX+1 entries of 2 bits each, with one synchronous write port, one combinational read port for the consumer, one combinational read port for assign_rd, and a synchronous clear.
- FSM, counter and conflict logic stay in implication_consumer.

## Test plan
- Assign then duplicate: with MAX=20, push 6'd7 (var 3 true). Expect prop_valid_o with prop_var_o=3, prop_val_o=1, assign_rd(3)=2'b11, count=1. Then push 6'd7 again: no prop_valid_o, count stays 1.
- Conflict: after var 3 true, push 6'd6 (var 3 false). Expect conflict_o=1, conflict_var_o=3, no further fifo_rd_o despite a non-empty FIFO. Then pulse clear_i: conflict_o=0, assign_rd(3)=2'b00, count=0.
- Backpressure: hold prop_ready_i=0 for 10 cycles after 6'd11 (var 5 true). Expect prop_valid_o, var 5 and value 1 held stable, no pops. Release ready: handshake completes in one cycle.
- Illegal index: push 6'd1 (var 0) and 6'd43 (var 21). Expect both discarded, no table change, count=0, FSM back in IDLE each time.
- Mid-operation reset: assert rst_i in the CHECK cycle of 6'd9 (var 4 true). Expect assign_rd(4)=2'b00, prop_valid_o never asserted, all outputs at reset values.
- Gating and latency: with en_i=0 and a non-empty FIFO, expect no fifo_rd_o. With en_i=1, expect fifo_rd_o exactly 1 cycle after the decision and prop_valid_o 4 cycles after the decision.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types and helpers for the BCP implication consumer.
// Holds formula sizing, the 2-bit assignment encoding, the consumer FSM states
// and field-extract helpers for packed {var, value} implications.
package bcp_pkg;

  localparam int FORMULA_MAX_VARIABLE    = 20;
  localparam int VARIABLE_ENCODING_LEN   = $clog2(FORMULA_MAX_VARIABLE + 1);
  localparam int VARIABLE_ASSIGNMENT_LEN = 1;
  localparam int WIDTH                   = VARIABLE_ENCODING_LEN + VARIABLE_ASSIGNMENT_LEN;

  typedef logic [VARIABLE_ENCODING_LEN-1:0] var_t;
  typedef logic [WIDTH-1:0]                 impl_t;
  typedef logic [1:0]                       assign_t;

  localparam var_t VAR_MAX = var_t'(FORMULA_MAX_VARIABLE);

  // Bit 1 marks "assigned", bit 0 carries the value.
  localparam assign_t ASSIGN_UNASSIGNED = 2'b00;
  localparam assign_t ASSIGN_FALSE      = 2'b10;
  localparam assign_t ASSIGN_TRUE       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_CHECK,
    ST_EMIT,
    ST_CONFLICT
  } cons_state_e;

  function automatic var_t impl_var(input impl_t impl);
    return impl[WIDTH-1:1];
  endfunction

  function automatic logic impl_val(input impl_t impl);
    return impl[0];
  endfunction

  // Variable 0 is reserved; anything above the formula size is illegal.
  function automatic logic var_in_range(input var_t v);
    return (v != '0) && (v <= VAR_MAX);
  endfunction

endpackage

// File: rtl/assignment_table.sv
// Variable assignment table: MAX+1 two-bit entries, one sync write port,
// two combinational read ports (consumer check, external lookup).
// Ports: clk_i/rst_i/clear_i, we_i/wr_var_i/wr_val_i, rd_a_*, rd_b_*; out-of-range reads return 00.
module assignment_table
  import bcp_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    clear_i,
  input  logic    we_i,
  input  var_t    wr_var_i,
  input  assign_t wr_val_i,
  input  var_t    rd_a_var_i,
  output assign_t rd_a_o,
  input  var_t    rd_b_var_i,
  output assign_t rd_b_o
);

  localparam int N_ENTRIES = FORMULA_MAX_VARIABLE + 1;

  assign_t tbl_q [N_ENTRIES];
  assign_t tbl_d [N_ENTRIES];

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      tbl_d[i] = tbl_q[i];
      // Entry 0 is never written so it always reads back as unassigned.
      if (we_i && (i != 0) && (wr_var_i == var_t'(i))) begin
        tbl_d[i] = wr_val_i;
      end
      if (clear_i) begin
        tbl_d[i] = ASSIGN_UNASSIGNED;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (rst_i) begin
        tbl_q[i] <= ASSIGN_UNASSIGNED;
      end else begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  function automatic assign_t lookup(input var_t v);
    assign_t r;
    r = ASSIGN_UNASSIGNED;
    for (int i = 1; i < N_ENTRIES; i++) begin
      if (v == var_t'(i)) begin
        r = tbl_q[i];
      end
    end
    return r;
  endfunction

  always_comb begin
    rd_a_o = lookup(rd_a_var_i);
    rd_b_o = lookup(rd_b_var_i);
  end

endmodule

// File: rtl/implication_consumer.sv
// Implication consumer: pops one implication at a time from the FIFO, checks it
// against the assignment table, then emits it (new), drops it (duplicate) or flags a sticky conflict.
// Ports: FIFO pop (fifo_*), valid/ready propagation out (prop_*), conflict status, table lookup, assigned count.
module implication_consumer
  import bcp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_implication_i,
  output logic        prop_valid_o,
  input  logic        prop_ready_i,
  output logic [VARIABLE_ENCODING_LEN-1:0] prop_var_o,
  output logic        prop_val_o,
  output logic        conflict_o,
  output logic [VARIABLE_ENCODING_LEN-1:0] conflict_var_o,
  input  logic [VARIABLE_ENCODING_LEN-1:0] assign_rd_var_i,
  output logic [1:0]  assign_rd_o,
  output logic [VARIABLE_ENCODING_LEN-1:0] assigned_count_o
);

  cons_state_e state_q, state_d;
  var_t        cur_var_q, cur_var_d;
  logic        cur_val_q, cur_val_d;
  logic        prop_valid_q, prop_valid_d;
  var_t        prop_var_q, prop_var_d;
  logic        prop_val_q, prop_val_d;
  logic        conflict_q, conflict_d;
  var_t        conflict_var_q, conflict_var_d;
  var_t        count_q, count_d;

  logic        tbl_we;
  assign_t     tbl_wval;
  assign_t     cur_entry;

  assignment_table u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .we_i       (tbl_we),
    .wr_var_i   (cur_var_q),
    .wr_val_i   (tbl_wval),
    .rd_a_var_i (cur_var_q),
    .rd_a_o     (cur_entry),
    .rd_b_var_i (assign_rd_var_i),
    .rd_b_o     (assign_rd_o)
  );

  always_comb begin
    state_d        = state_q;
    cur_var_d      = cur_var_q;
    cur_val_d      = cur_val_q;
    prop_valid_d   = prop_valid_q;
    prop_var_d     = prop_var_q;
    prop_val_d     = prop_val_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    count_d        = count_q;
    tbl_we         = 1'b0;
    tbl_wval       = {1'b1, cur_val_q};

    case (state_q)
      ST_IDLE: begin
        if (en_i && !fifo_empty_i && !conflict_q) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // FIFO data is valid the cycle after the pop pulse.
        cur_var_d = impl_var(fifo_implication_i);
        cur_val_d = impl_val(fifo_implication_i);
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        if (!var_in_range(cur_var_q)) begin
          state_d = ST_IDLE;
        end else if (cur_entry == ASSIGN_UNASSIGNED) begin
          tbl_we       = 1'b1;
          count_d      = (count_q == VAR_MAX) ? count_q : count_q + var_t'(1);
          prop_valid_d = 1'b1;
          prop_var_d   = cur_var_q;
          prop_val_d   = cur_val_q;
          state_d      = ST_EMIT;
        end else if (cur_entry == {1'b1, cur_val_q}) begin
          state_d = ST_IDLE;
        end else begin
          conflict_d     = 1'b1;
          conflict_var_d = cur_var_q;
          state_d        = ST_CONFLICT;
        end
      end
      ST_EMIT: begin
        if (prop_ready_i) begin
          prop_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      ST_CONFLICT: begin
        state_d = ST_CONFLICT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear behaves exactly like reset; any in-flight implication is dropped.
    if (clear_i) begin
      state_d        = ST_IDLE;
      cur_var_d      = '0;
      cur_val_d      = 1'b0;
      prop_valid_d   = 1'b0;
      prop_var_d     = '0;
      prop_val_d     = 1'b0;
      conflict_d     = 1'b0;
      conflict_var_d = '0;
      count_d        = '0;
      tbl_we         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cur_var_q      <= '0;
      cur_val_q      <= 1'b0;
      prop_valid_q   <= 1'b0;
      prop_var_q     <= '0;
      prop_val_q     <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      cur_var_q      <= cur_var_d;
      cur_val_q      <= cur_val_d;
      prop_valid_q   <= prop_valid_d;
      prop_var_q     <= prop_var_d;
      prop_val_q     <= prop_val_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      count_q        <= count_d;
    end
  end

  assign fifo_rd_o        = (state_q == ST_READ);
  assign prop_valid_o     = prop_valid_q;
  assign prop_var_o       = prop_var_q;
  assign prop_val_o       = prop_val_q;
  assign conflict_o       = conflict_q;
  assign conflict_var_o   = conflict_var_q;
  assign assigned_count_o = count_q;

endmodule
